// File: rtl/countdown_input_ctrl.sv
// countdown_input_ctrl: front-end for the two-digit BCD countdown stage.
// Synchronises and debounces the pause key and display switch, clamps the
// BCD presets to 0-9, runs the OFF/SET/RUN/PAUSED/DONE state machine and
// issues the load pulse and gated count-down ticks.
// Optional build macro HOLD_RESTART_EN: holding the pause key in PAUSED or
// DONE for HOLD_CYCLES cycles returns the controller to SET.
module countdown_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 50000000,
    parameter int HOLD_CYCLES     = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pause_n,
    input  logic       switch,
    input  logic [3:0] set1,
    input  logic [3:0] set2,
    input  logic       at_zero,
    output logic       blank,
    output logic       load,
    output logic [3:0] ld_ones,
    output logic [3:0] ld_tens,
    output logic       tick,
    output logic       running,
    output logic       done
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SET    = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Preset switches above 9 are not valid BCD; saturate them to 9.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        clamp_bcd = (v > 4'd9) ? 4'd9 : v;
    endfunction

    logic            pause_s1_r, pause_s2_r, switch_s1_r, switch_s2_r;
    logic [3:0]      set1_s1_r, set1_s2_r, set2_s1_r, set2_s2_r;
    logic            pause_db_r, pause_db_d_r, switch_db_r;
    logic [DB_W-1:0] pause_cnt_r, switch_cnt_r;
    logic            press_s;
    state_t          state_r, state_nxt_s;
    logic            load_s, tick_s, hold_hit_s;
    logic [DIV_W-1:0] div_r, div_nxt_s;
    logic            blank_r, load_r, tick_r, running_r, done_r;
    logic [3:0]      ld_ones_r, ld_tens_r;

    // Two-flop synchronisers; the active-low key idles high.
    always_ff @(posedge clock) begin
        if (reset) begin
            pause_s1_r  <= 1'b1;
            pause_s2_r  <= 1'b1;
            switch_s1_r <= 1'b0;
            switch_s2_r <= 1'b0;
            set1_s1_r   <= 4'd0;
            set1_s2_r   <= 4'd0;
            set2_s1_r   <= 4'd0;
            set2_s2_r   <= 4'd0;
        end else begin
            pause_s1_r  <= pause_n;
            pause_s2_r  <= pause_s1_r;
            switch_s1_r <= switch;
            switch_s2_r <= switch_s1_r;
            set1_s1_r   <= set1;
            set1_s2_r   <= set1_s1_r;
            set2_s1_r   <= set2;
            set2_s2_r   <= set2_s1_r;
        end
    end

    // Pause key debounce; the delayed copy feeds the falling-edge detector.
    always_ff @(posedge clock) begin
        if (reset) begin
            pause_db_r   <= 1'b1;
            pause_db_d_r <= 1'b1;
            pause_cnt_r  <= {DB_W{1'b0}};
        end else begin
            pause_db_d_r <= pause_db_r;
            if (pause_s2_r == pause_db_r) begin
                pause_cnt_r <= {DB_W{1'b0}};
            end else if (pause_cnt_r == DB_LAST) begin
                pause_db_r  <= pause_s2_r;
                pause_cnt_r <= {DB_W{1'b0}};
            end else begin
                pause_cnt_r <= pause_cnt_r + DB_W'(1);
            end
        end
    end

    // Display switch debounce.
    always_ff @(posedge clock) begin
        if (reset) begin
            switch_db_r  <= 1'b0;
            switch_cnt_r <= {DB_W{1'b0}};
        end else begin
            if (switch_s2_r == switch_db_r) begin
                switch_cnt_r <= {DB_W{1'b0}};
            end else if (switch_cnt_r == DB_LAST) begin
                switch_db_r  <= switch_s2_r;
                switch_cnt_r <= {DB_W{1'b0}};
            end else begin
                switch_cnt_r <= switch_cnt_r + DB_W'(1);
            end
        end
    end

    // Only the debounced press (1->0) is an event; release is ignored.
    assign press_s = pause_db_d_r & ~pause_db_r;

`ifdef HOLD_RESTART_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    logic [HOLD_W-1:0] hold_r;
    logic              hold_active_s;

    assign hold_active_s = ((state_r == ST_PAUSED) || (state_r == ST_DONE)) && !pause_db_r;
    assign hold_hit_s    = hold_active_s && (hold_r == HOLD_LAST);

    // Hold timer restarts on release and on every state change.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_r <= {HOLD_W{1'b0}};
        end else if ((state_nxt_s != state_r) || !hold_active_s) begin
            hold_r <= {HOLD_W{1'b0}};
        end else begin
            hold_r <= hold_r + HOLD_W'(1);
        end
    end
`else
    assign hold_hit_s = 1'b0;
`endif

    // Next-state logic; switch-off overrides everything, at_zero beats press.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        if (!switch_db_r) begin
            state_nxt_s = ST_OFF;
        end else begin
            case (state_r)
                ST_OFF: state_nxt_s = ST_SET;
                ST_SET: begin
                    if (press_s) begin
                        state_nxt_s = ST_RUN;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_SET;
                    end
                end
                ST_RUN: begin
                    if (at_zero) begin
                        state_nxt_s = ST_DONE;
                    end else if (press_s) begin
                        state_nxt_s = ST_PAUSED;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_PAUSED: begin
                    if (press_s) begin
                        state_nxt_s = ST_RUN;
                    end else if (hold_hit_s) begin
                        state_nxt_s = ST_SET;
                    end else begin
                        state_nxt_s = ST_PAUSED;
                    end
                end
                ST_DONE: begin
                    if (press_s || hold_hit_s) begin
                        state_nxt_s = ST_SET;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_OFF;
            endcase
        end
    end

    // Tick divider: counts only while staying in RUN, holds across a pause.
    always_comb begin
        div_nxt_s = div_r;
        tick_s    = 1'b0;
        if (load_s) begin
            div_nxt_s = {DIV_W{1'b0}};
        end else if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
            if (div_r == DIV_LAST) begin
                div_nxt_s = {DIV_W{1'b0}};
                tick_s    = 1'b1;
            end else begin
                div_nxt_s = div_r + DIV_W'(1);
            end
        end else if ((state_nxt_s == ST_RUN) || (state_nxt_s == ST_PAUSED)) begin
            div_nxt_s = div_r;
        end else begin
            div_nxt_s = {DIV_W{1'b0}};
        end
    end

    // State, divider and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_OFF;
            div_r     <= {DIV_W{1'b0}};
            blank_r   <= 1'b1;
            load_r    <= 1'b0;
            tick_r    <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            ld_ones_r <= 4'd0;
            ld_tens_r <= 4'd0;
        end else begin
            state_r   <= state_nxt_s;
            div_r     <= div_nxt_s;
            blank_r   <= (state_nxt_s == ST_OFF);
            load_r    <= load_s;
            tick_r    <= tick_s;
            running_r <= (state_nxt_s == ST_RUN);
            done_r    <= (state_nxt_s == ST_DONE);
            if (state_r == ST_SET) begin
                ld_ones_r <= clamp_bcd(set1_s2_r);
                ld_tens_r <= clamp_bcd(set2_s2_r);
            end else begin
                ld_ones_r <= ld_ones_r;
                ld_tens_r <= ld_tens_r;
            end
        end
    end

    assign blank   = blank_r;
    assign load    = load_r;
    assign tick    = tick_r;
    assign running = running_r;
    assign done    = done_r;
    assign ld_ones = ld_ones_r;
    assign ld_tens = ld_tens_r;

endmodule

// File: tb/tb_countdown_input_ctrl.sv
// Self-checking bench for countdown_input_ctrl with small timing parameters.
module tb_countdown_input_ctrl;

    localparam int DEB  = 4;
    localparam int TD   = 10;
    localparam int HOLD = 20;
    localparam int M_OFF = 0, M_SET = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

    logic       clock = 1'b0;
    logic       reset, pause_n, switch, at_zero;
    logic [3:0] set1, set2;
    logic       blank, load, tick, running, done;
    logic [3:0] ld_ones, ld_tens;

    countdown_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV(TD),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clock(clock), .reset(reset), .pause_n(pause_n), .switch(switch),
        .set1(set1), .set2(set2), .at_zero(at_zero), .blank(blank),
        .load(load), .ld_ones(ld_ones), .ld_tens(ld_tens), .tick(tick),
        .running(running), .done(done)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int n_load  = 0;
    int n_tick  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    bit lag_p [0:1];
    bit lag_sw[0:1];
    int lag_s1[0:1];
    int lag_s2[0:1];
    bit m_db_p, m_db_sw, m_press_next;
    int m_diff_p, m_diff_sw, m_state, m_run, m_low;
    bit e_blank, e_load, e_tick, e_running, e_done;
    int e_ld1, e_ld2;

    task automatic model_step();
        bit sp, ssw, press, ld;
        int s1v, s2v, ns;
        if (reset) begin
            lag_p = '{1'b1, 1'b1}; lag_sw = '{1'b0, 1'b0};
            lag_s1 = '{0, 0};      lag_s2 = '{0, 0};
            m_db_p = 1'b1; m_db_sw = 1'b0; m_press_next = 1'b0;
            m_diff_p = 0; m_diff_sw = 0; m_state = M_OFF; m_run = 0; m_low = 0;
            e_blank = 1'b1; e_load = 1'b0; e_tick = 1'b0; e_running = 1'b0; e_done = 1'b0;
            e_ld1 = 0; e_ld2 = 0;
            return;
        end
        // samples that made it through two flops
        sp = lag_p[1]; ssw = lag_sw[1]; s1v = lag_s1[1]; s2v = lag_s2[1];
        lag_p[1] = lag_p[0];   lag_p[0] = pause_n;
        lag_sw[1] = lag_sw[0]; lag_sw[0] = switch;
        lag_s1[1] = lag_s1[0]; lag_s1[0] = int'(set1);
        lag_s2[1] = lag_s2[0]; lag_s2[0] = int'(set2);
        press = m_press_next;
        ns = m_state; ld = 1'b0;
        if (!m_db_sw) ns = M_OFF;
        else if (m_state == M_OFF) ns = M_SET;
        else if (m_state == M_SET && press) begin ns = M_RUN; ld = 1'b1; end
        else if (m_state == M_RUN && at_zero) ns = M_DONE;
        else if (m_state == M_RUN && press) ns = M_PAUSED;
        else if (m_state == M_PAUSED && press) ns = M_RUN;
        else if (m_state == M_DONE && press) ns = M_SET;
`ifdef HOLD_RESTART_EN
        else if ((m_state == M_PAUSED || m_state == M_DONE) && !m_db_p && m_low == HOLD - 1) ns = M_SET;
`endif
        // ticks: every TD-th cycle spent continuously running since the load
        e_tick = 1'b0;
        if (ld) m_run = 0;
        else if (m_state == M_RUN && ns == M_RUN) begin
            m_run++;
            if (m_run % TD == 0) e_tick = 1'b1;
        end else if (ns != M_RUN && ns != M_PAUSED) m_run = 0;
        if (ns == m_state && (m_state == M_PAUSED || m_state == M_DONE) && !m_db_p) m_low++;
        else m_low = 0;
        if (m_state == M_SET) begin
            e_ld1 = (s1v > 9) ? 9 : s1v;
            e_ld2 = (s2v > 9) ? 9 : s2v;
        end
        // debounce: DEB consecutive differing samples flip the level
        m_press_next = 1'b0;
        if (sp != m_db_p) begin
            m_diff_p++;
            if (m_diff_p == DEB) begin m_db_p = sp; m_diff_p = 0; m_press_next = !sp; end
        end else m_diff_p = 0;
        if (ssw != m_db_sw) begin
            m_diff_sw++;
            if (m_diff_sw == DEB) begin m_db_sw = ssw; m_diff_sw = 0; end
        end else m_diff_sw = 0;
        e_load = ld; e_blank = (ns == M_OFF); e_running = (ns == M_RUN); e_done = (ns == M_DONE);
        m_state = ns;
    endtask

    always @(posedge clock) begin
        cyc++;
        if (cmp_en) begin
            if (tick === 1'b1) n_tick++;
            if (load === 1'b1) n_load++;
        end
        model_step();
        if (reset) cmp_en = 1'b1;
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("blank", blank, e_blank);
            check("load", load, e_load);
            check("tick", tick, e_tick);
            check("running", running, e_running);
            check("done", done, e_done);
            check("ld_ones", ld_ones, e_ld1);
            check("ld_tens", ld_tens, e_ld2);
        end
    end

    // sel: 0 load, 1 tick, 2 running
    task automatic wait_sig(input string nm, input int sel, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if ((sel == 0 && load === 1'b1) || (sel == 1 && tick === 1'b1) ||
                (sel == 2 && running === 1'b1)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_total++;
            $display("FAIL wait_%s: not seen within %0d cycles", nm, limit);
        end
    endtask

    int t0, t_load, t_tk, t_res, base;

    initial begin
        reset = 1'b1; pause_n = 1'b1; switch = 1'b0; at_zero = 1'b0;
        set1 = 4'd0; set2 = 4'd0;
        repeat (3) @(negedge clock);
        check("rst_blank", blank, 1); check("rst_load", load, 0);
        check("rst_tick", tick, 0);   check("rst_running", running, 0);
        check("rst_done", done, 0);   check("rst_ld_ones", ld_ones, 0);
        check("rst_ld_tens", ld_tens, 0);
        reset = 1'b0;

        // power on with out-of-range ones preset
        switch = 1'b1; set1 = 4'hC; set2 = 4'd3;
        repeat (12) @(negedge clock);
        check("set_blank", blank, 0);

        // bouncing key: no state change
        for (int i = 0; i < 10; i++) begin
            pause_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clock);
        end
        check("bounce_no_load", n_load, 0);
        check("bounce_not_running", running, 0);
        pause_n = 1'b0; t0 = cyc;
        wait_sig("load", 0, 20, t_load);
        check("press_latency", t_load - t0, 7);
        check("load_ld_ones", ld_ones, 9);
        check("load_ld_tens", ld_tens, 3);
        for (int k = 1; k <= 3; k++) begin
            wait_sig("tick", 1, 15, t_tk);
            check($sformatf("tick%0d_offset", k), t_tk - t_load, 10 * k);
        end

        // pause with the divider at 6, then resume
        pause_n = 1'b1;
        repeat (10) @(negedge clock);
        pause_n = 1'b0;
        repeat (8) @(negedge clock);
        check("paused_running", running, 0);
        pause_n = 1'b1; base = n_tick;
        repeat (14) @(negedge clock);
        check("pause_no_tick", n_tick - base, 0);
        check("pause_no_load", n_load, 1);
        pause_n = 1'b0;
        wait_sig("resume", 2, 20, t_res);
        pause_n = 1'b1;
        wait_sig("resume_tick", 1, 20, t_tk);
        check("resume_tick_offset", t_tk - t_res, 4);

        // at_zero arriving on the wrap cycle suppresses the tick
        repeat (9) @(negedge clock);
        at_zero = 1'b1; base = n_tick;
        @(negedge clock);
        check("zero_done", done, 1);
        repeat (2) @(negedge clock);
        check("zero_no_tick", n_tick - base, 0);
        check("zero_not_running", running, 0);
        pause_n = 1'b0;
        repeat (10) @(negedge clock);
        check("done_to_set_done", done, 0);
        check("done_to_set_blank", blank, 0);
        at_zero = 1'b0; pause_n = 1'b1;
        repeat (8) @(negedge clock);

        // switch-off beats a simultaneous press in RUN
        pause_n = 1'b0;
        wait_sig("load2", 0, 20, t_load);
        pause_n = 1'b1;
        repeat (8) @(negedge clock);
        check("run_before_off", running, 1);
        pause_n = 1'b0; switch = 1'b0;
        repeat (9) @(negedge clock);
        check("off_blank", blank, 1);
        check("off_running", running, 0);

        // reset in the middle of RUN
        switch = 1'b1; pause_n = 1'b1;
        repeat (10) @(negedge clock);
        pause_n = 1'b0;
        wait_sig("load3", 0, 20, t_load);
        pause_n = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_blank", blank, 1);  check("mid_rst_running", running, 0);
        check("mid_rst_tick", tick, 0);    check("mid_rst_load", load, 0);
        check("mid_rst_ld_ones", ld_ones, 0);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // long hold while PAUSED
        pause_n = 1'b0;
        wait_sig("load4", 0, 20, t_load);
        pause_n = 1'b1;
        repeat (8) @(negedge clock);
        pause_n = 1'b0;
        repeat (36) @(negedge clock);
        check("hold_not_running", running, 0);
        pause_n = 1'b1;
        repeat (10) @(negedge clock);
        check("hold_release_not_running", running, 0);
        base = n_load;
        pause_n = 1'b0;
        repeat (10) @(negedge clock);
        check("after_hold_running", running, 1);
`ifdef HOLD_RESTART_EN
        check("after_hold_load", n_load - base, 1);
`else
        check("after_hold_load", n_load - base, 0);
`endif
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
